// File: rtl/traffic_pkg.sv
// Shared types and constants for the NS/EW intersection phase sequencer:
// phase codes, light encodings, counter limits and duration-register selects.
package traffic_pkg;

  localparam int CNT_W = 6;
  localparam logic [CNT_W-1:0] CNT_MAX = 6'd59;

  typedef enum logic [2:0] {
    PH_NS_G  = 3'd0,
    PH_NS_Y  = 3'd1,
    PH_RED_A = 3'd2,
    PH_EW_G  = 3'd3,
    PH_EW_Y  = 3'd4,
    PH_RED_B = 3'd5,
    PH_FLASH = 3'd6
  } phase_e;

  // Light heads are {R,Y,G}
  localparam logic [2:0] LT_R   = 3'b100;
  localparam logic [2:0] LT_Y   = 3'b010;
  localparam logic [2:0] LT_G   = 3'b001;
  localparam logic [2:0] LT_OFF = 3'b000;

  typedef enum logic [1:0] {
    SEL_G_NS = 2'd0,
    SEL_G_EW = 2'd1,
    SEL_Y    = 2'd2,
    SEL_R    = 2'd3
  } cfg_sel_e;

  // FLASH and any illegal code both fall through to RED_B.
  function automatic phase_e next_phase(input phase_e ph);
    case (ph)
      PH_NS_G:  return PH_NS_Y;
      PH_NS_Y:  return PH_RED_A;
      PH_RED_A: return PH_EW_G;
      PH_EW_G:  return PH_EW_Y;
      PH_EW_Y:  return PH_RED_B;
      PH_RED_B: return PH_NS_G;
      default:  return PH_RED_B;
    endcase
  endfunction

  function automatic cfg_sel_e dur_sel(input phase_e ph);
    case (ph)
      PH_NS_G:           return SEL_G_NS;
      PH_EW_G:           return SEL_G_EW;
      PH_NS_Y, PH_EW_Y:  return SEL_Y;
      default:           return SEL_R;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] clamp_dur(input logic [CNT_W-1:0] v);
    if (v == '0)
      return CNT_W'(1);
    if (v > CNT_MAX)
      return CNT_MAX;
    return v;
  endfunction

endpackage

// File: rtl/traffic_dur_regs.sv
// Four clamping duration registers with a write port and a combinational
// read-by-phase port that forwards a same-cycle write to the reader.
module traffic_dur_regs
  import traffic_pkg::*;
#(
  parameter logic [CNT_W-1:0] G_NS_DEF = 6'd25,
  parameter logic [CNT_W-1:0] G_EW_DEF = 6'd20,
  parameter logic [CNT_W-1:0] Y_DEF    = 6'd3,
  parameter logic [CNT_W-1:0] R_DEF    = 6'd2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [1:0]       wr_sel,
  input  logic [CNT_W-1:0] wr_data,
  input  phase_e           rd_phase,
  output logic [CNT_W-1:0] rd_dur
);

  logic [CNT_W-1:0] dur_q [4];
  logic [CNT_W-1:0] wr_val;
  logic [1:0]       rd_sel;

  assign wr_val = clamp_dur(wr_data);
  assign rd_sel = dur_sel(rd_phase);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dur_q[SEL_G_NS] <= clamp_dur(G_NS_DEF);
      dur_q[SEL_G_EW] <= clamp_dur(G_EW_DEF);
      dur_q[SEL_Y]    <= clamp_dur(Y_DEF);
      dur_q[SEL_R]    <= clamp_dur(R_DEF);
    end else if (wr_en) begin
      dur_q[wr_sel] <= wr_val;
    end
  end

  // Write-through so a load coinciding with a write sees the new value.
  always_comb begin
    rd_dur = dur_q[rd_sel];
    if (wr_en && (wr_sel == rd_sel))
      rd_dur = wr_val;
  end

endmodule

// File: rtl/traffic_phase_ctrl.sv
// Two-road phase sequencer: tick-driven phase FSM with a seconds down-counter,
// registered light heads, and a night flash mode with alternating yellows.
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int unsigned G_NS_DEF = 25,
  parameter int unsigned G_EW_DEF = 20,
  parameter int unsigned Y_DEF    = 3,
  parameter int unsigned R_DEF    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             night,
  input  logic             cfg_we,
  input  logic [1:0]       cfg_sel,
  input  logic [CNT_W-1:0] cfg_data,
  output logic [2:0]       ns_light,
  output logic [2:0]       ew_light,
  output logic [CNT_W-1:0] count,
  output logic [2:0]       phase
);

  localparam logic [CNT_W-1:0] RST_CNT = clamp_dur(CNT_W'(G_NS_DEF));

  phase_e           phase_q, phase_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             flash_on_q, flash_on_d;
  logic [2:0]       ns_q, ns_d;
  logic [2:0]       ew_q, ew_d;
  phase_e           load_phase;
  logic [CNT_W-1:0] load_dur;

  // The only phases ever loaded from here are the successor (normal running)
  // or RED_B (FLASH exit / illegal recovery), and next_phase yields exactly that.
  assign load_phase = next_phase(phase_q);

  traffic_dur_regs #(
    .G_NS_DEF(CNT_W'(G_NS_DEF)),
    .G_EW_DEF(CNT_W'(G_EW_DEF)),
    .Y_DEF   (CNT_W'(Y_DEF)),
    .R_DEF   (CNT_W'(R_DEF))
  ) u_dur_regs (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (cfg_we),
    .wr_sel  (cfg_sel),
    .wr_data (cfg_data),
    .rd_phase(load_phase),
    .rd_dur  (load_dur)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q    <= PH_NS_G;
      count_q    <= RST_CNT;
      flash_on_q <= 1'b0;
      ns_q       <= LT_G;
      ew_q       <= LT_R;
    end else begin
      phase_q    <= phase_d;
      count_q    <= count_d;
      flash_on_q <= flash_on_d;
      ns_q       <= ns_d;
      ew_q       <= ew_d;
    end
  end

  always_comb begin
    phase_d    = phase_q;
    count_d    = count_q;
    flash_on_d = flash_on_q;
    if (3'(phase_q) > 3'(PH_FLASH)) begin
      phase_d = PH_RED_B;
      count_d = load_dur;
    end else if (tick) begin
      if (phase_q == PH_FLASH) begin
        if (night) begin
          flash_on_d = ~flash_on_q;
        end else begin
          phase_d = PH_RED_B;
          count_d = load_dur;
        end
      end else if (night) begin
        phase_d    = PH_FLASH;
        count_d    = '0;
        flash_on_d = 1'b1;
      end else if (count_q > CNT_W'(1)) begin
        count_d = count_q - CNT_W'(1);
      end else begin
        phase_d = load_phase;
        count_d = load_dur;
      end
    end
  end

  // Lights decode from the next state so they change in the same clock as the phase.
  always_comb begin
    ns_d = LT_R;
    ew_d = LT_R;
    case (phase_d)
      PH_NS_G:  ns_d = LT_G;
      PH_NS_Y:  ns_d = LT_Y;
      PH_EW_G:  ew_d = LT_G;
      PH_EW_Y:  ew_d = LT_Y;
      PH_FLASH: begin
        ns_d = flash_on_d ? LT_Y : LT_OFF;
        ew_d = flash_on_d ? LT_Y : LT_OFF;
      end
      default: begin
        ns_d = LT_R;
        ew_d = LT_R;
      end
    endcase
  end

  assign ns_light = ns_q;
  assign ew_light = ew_q;
  assign count    = count_q;
  assign phase    = phase_q;

  a_no_conflict: assert property (@(posedge clk) disable iff (!rst_n)
    (phase_q == PH_FLASH) || (ns_q == LT_R) || (ew_q == LT_R));

endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// Bench for traffic_phase_ctrl: vector table, hand-written corner sequences,
// and randomized stimulus against a seconds-level reference model.
module tb_traffic_phase_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       night = 1'b0;
  logic       cfg_we = 1'b0;
  logic [1:0] cfg_sel = 2'd0;
  logic [5:0] cfg_data = 6'd0;
  logic [2:0] ns_light, ew_light, phase;
  logic [5:0] count;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  traffic_phase_ctrl dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .tick    (tick),
    .night   (night),
    .cfg_we  (cfg_we),
    .cfg_sel (cfg_sel),
    .cfg_data(cfg_data),
    .ns_light(ns_light),
    .ew_light(ew_light),
    .count   (count),
    .phase   (phase)
  );

  // Reference model: phase index into the 6-step cycle (6 = flash),
  // seconds remaining, and the four programmed durations.
  int m_phase, m_count;
  int m_dur[4];
  bit m_flash;
  int dur_idx[6] = '{0, 2, 3, 1, 2, 3};
  int ns_tab[6]  = '{1, 2, 4, 4, 4, 4};
  int ew_tab[6]  = '{4, 4, 4, 1, 2, 4};

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_count = 25;
    m_dur   = '{25, 20, 3, 2};
    m_flash = 1'b0;
  endtask

  task automatic model_step(input bit t, input bit n, input bit we, input int sel, input int d);
    if (we)
      m_dur[sel] = (d == 0) ? 1 : ((d > 59) ? 59 : d);
    if (t) begin
      if (m_phase == 6) begin
        if (n) m_flash = !m_flash;
        else begin
          m_phase = 5;
          m_count = m_dur[3];
        end
      end else if (n) begin
        m_phase = 6;
        m_count = 0;
        m_flash = 1'b1;
      end else if (m_count > 1) begin
        m_count = m_count - 1;
      end else begin
        m_phase = (m_phase + 1) % 6;
        m_count = m_dur[dur_idx[m_phase]];
      end
    end
  endtask

  task automatic model_check(input string tag);
    int e_ns, e_ew;
    if (m_phase == 6) begin
      e_ns = m_flash ? 2 : 0;
      e_ew = e_ns;
    end else begin
      e_ns = ns_tab[m_phase];
      e_ew = ew_tab[m_phase];
    end
    chk({tag, "_phase"}, 32'(phase), m_phase);
    chk({tag, "_count"}, 32'(count), m_count);
    chk({tag, "_ns"}, 32'(ns_light), e_ns);
    chk({tag, "_ew"}, 32'(ew_light), e_ew);
  endtask

  task automatic step(input bit t, input bit n, input bit we, input logic [1:0] sel, input logic [5:0] d);
    @(negedge clk);
    tick = t; night = n; cfg_we = we; cfg_sel = sel; cfg_data = d;
    @(posedge clk);
    #1;
    model_step(t, n, we, int'(sel), int'(d));
    tick = 1'b0;
    cfg_we = 1'b0;
  endtask

  task automatic ticks(input int k);
    repeat (k) step(1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0; tick = 1'b0; night = 1'b0; cfg_we = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic chk_state(input string tag, input int ph, input int cnt, input int ns, input int ew);
    chk({tag, "_phase"}, 32'(phase), ph);
    chk({tag, "_count"}, 32'(count), cnt);
    chk({tag, "_ns"}, 32'(ns_light), ns);
    chk({tag, "_ew"}, 32'(ew_light), ew);
  endtask

  typedef struct {
    bit         t;
    bit         n;
    bit         we;
    logic [1:0] sel;
    logic [5:0] d;
    int         ph;
    int         cnt;
    logic [2:0] ns;
    logic [2:0] ew;
  } vec_t;

  vec_t vt[12];
  int   loads[$];
  int   exp_loads[6] = '{3, 2, 20, 3, 2, 25};
  int   ew_bad;
  int   prev_ph;
  bit   r_night;

  initial begin
    vt[0]  = '{1'b0, 1'b0, 1'b0, 2'd0, 6'd0,  0, 25, 3'b001, 3'b100};
    vt[1]  = '{1'b1, 1'b0, 1'b0, 2'd0, 6'd0,  0, 24, 3'b001, 3'b100};
    vt[2]  = '{1'b0, 1'b0, 1'b1, 2'd1, 6'd62, 0, 24, 3'b001, 3'b100};
    vt[3]  = '{1'b1, 1'b0, 1'b1, 2'd2, 6'd0,  0, 23, 3'b001, 3'b100};
    vt[4]  = '{1'b0, 1'b1, 1'b0, 2'd0, 6'd0,  0, 23, 3'b001, 3'b100};
    vt[5]  = '{1'b1, 1'b1, 1'b0, 2'd0, 6'd0,  6, 0,  3'b010, 3'b010};
    vt[6]  = '{1'b1, 1'b1, 1'b0, 2'd0, 6'd0,  6, 0,  3'b000, 3'b000};
    vt[7]  = '{1'b0, 1'b0, 1'b0, 2'd0, 6'd0,  6, 0,  3'b000, 3'b000};
    vt[8]  = '{1'b1, 1'b0, 1'b0, 2'd0, 6'd0,  5, 2,  3'b100, 3'b100};
    vt[9]  = '{1'b1, 1'b0, 1'b1, 2'd3, 6'd63, 5, 1,  3'b100, 3'b100};
    vt[10] = '{1'b1, 1'b0, 1'b1, 2'd0, 6'd12, 0, 12, 3'b001, 3'b100};
    vt[11] = '{1'b1, 1'b0, 1'b0, 2'd0, 6'd0,  0, 11, 3'b001, 3'b100};

    // Reset state, then table vectors (clamping, night entry/exit, write-through)
    do_reset();
    chk_state("reset", 0, 25, 1, 4);
    for (int i = 0; i < 12; i++) begin
      step(vt[i].t, vt[i].n, vt[i].we, vt[i].sel, vt[i].d);
      chk_state($sformatf("vec%0d", i), vt[i].ph, vt[i].cnt, 32'(vt[i].ns), 32'(vt[i].ew));
      $display("vec%0d tick=%0d night=%0d we=%0d -> phase=%0d count=%0d", i, vt[i].t, vt[i].n, vt[i].we, phase, count);
    end
    ticks(11);
    chk_state("clampY", 1, 1, 2, 4);
    ticks(1);
    chk_state("clampR", 2, 59, 4, 4);
    ticks(59);
    chk_state("clampGEW", 3, 59, 4, 1);

    // 25 ticks from reset, then a full 55-tick cycle
    do_reset();
    ticks(24);
    chk_state("pre_yellow", 0, 1, 1, 4);
    ticks(1);
    chk_state("ns_yellow", 1, 3, 2, 4);
    do_reset();
    loads.delete();
    ew_bad = 0;
    prev_ph = 0;
    for (int i = 0; i < 55; i++) begin
      ticks(1);
      if (int'(phase) != prev_ph) loads.push_back(int'(count));
      if ((ew_light == 3'b001) != (phase == 3'd3)) ew_bad++;
      prev_ph = int'(phase);
    end
    chk("cycle_nloads", 32'(loads.size()), 6);
    for (int i = 0; i < 6; i++)
      chk($sformatf("cycle_load%0d", i), (i < loads.size()) ? loads[i] : -1, exp_loads[i]);
    chk("cycle_ew_green_only_p3", ew_bad, 0);
    chk_state("cycle_end", 0, 25, 1, 4);
    $display("cycle loads recorded=%0d phase=%0d count=%0d", loads.size(), phase, count);

    // G_NS write mid-phase does not alter the running count
    do_reset();
    ticks(18);
    step(1'b0, 1'b0, 1'b1, 2'd0, 6'd10);
    chk_state("gns_wr", 0, 7, 1, 4);
    ticks(6);
    chk_state("gns_cnt1", 0, 1, 1, 4);
    ticks(1);
    chk_state("gns_adv", 1, 3, 2, 4);
    ticks(30);
    chk_state("gns_reload", 0, 10, 1, 4);

    // Night mode from EW_G at count 9
    do_reset();
    ticks(41);
    chk_state("ewg9", 3, 9, 4, 1);
    step(1'b0, 1'b1, 1'b0, 2'd0, 6'd0);
    chk_state("night_notick", 3, 9, 4, 1);
    step(1'b1, 1'b1, 1'b0, 2'd0, 6'd0);
    chk_state("flash_on", 6, 0, 2, 2);
    step(1'b1, 1'b1, 1'b0, 2'd0, 6'd0);
    chk_state("flash_off", 6, 0, 0, 0);
    step(1'b0, 1'b0, 1'b0, 2'd0, 6'd0);
    chk_state("day_notick", 6, 0, 0, 0);
    step(1'b1, 1'b0, 1'b0, 2'd0, 6'd0);
    chk_state("flash_exit", 5, 2, 4, 4);
    ticks(2);
    chk_state("back_nsg", 0, 25, 1, 4);

    // Asynchronous reset mid EW_Y with tick held high
    do_reset();
    ticks(50);
    chk_state("ewy", 4, 3, 4, 2);
    @(posedge clk);
    #3;
    tick = 1'b1;
    rst_n = 1'b0;
    #1;
    chk_state("async_rst", 0, 25, 1, 4);
    repeat (2) @(posedge clk);
    #1;
    chk_state("rst_held_tick", 0, 25, 1, 4);
    @(negedge clk);
    tick = 1'b0;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk_state("rst_release", 0, 25, 1, 4);
    model_reset();

    // Randomized stimulus against the model
    do_reset();
    model_check("rnd_start");
    r_night = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 99) < 3) r_night = !r_night;
      step(1'($urandom_range(0, 1)), r_night, ($urandom_range(0, 19) == 0),
           2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)));
      model_check($sformatf("rnd%0d", i));
    end
    $display("random phase=%0d count=%0d", phase, count);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
